// File: rtl/pipeline_processor.sv
// pipeline_processor
// Three-stage in-order datapath: register read -> ALU -> writeback/store.
// One register-register operation is accepted on every non-reset clock edge
// straight from the ports; there is no valid/handshake.
//
// Optional feature (compile-time macro PIPE_FORWARD_EN):
//   defined     - S1 operands are bypassed from the ALU output of the op in S2
//                 (rs == rd1, highest priority) or from Z of the op in S3
//                 (rs == rd2), so back-to-back dependent ops see fresh values.
//   not defined - no bypass; a consumer issued 1 or 2 cycles after its
//                 producer reads the stale register bank value.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-low reset
//   rs1/rs2  source register indices (5 bits)
//   rd       destination register index (5 bits)
//   func     ALU opcode (4 bits)
//   addr     data-memory store address; word index = addr[MEM_AW-1:0]
//   mem_out  registered copy of the value stored in the writeback stage
//
// Parameters:
//   MEM_AW   data-memory index width, depth = 2**MEM_AW words

module pipeline_processor #(
    parameter int MEM_AW = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [3:0]  func,
    input  logic [31:0] addr,
    output logic [31:0] mem_out
);

    localparam int MEM_DEPTH = 2 ** MEM_AW;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_MUL  = 4'd2,
        ALU_SELA = 4'd3,
        ALU_SELB = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_NOTA = 4'd8,
        ALU_NOTB = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_SLA  = 4'd11
    } alu_op_e;

    logic [31:0] regbank [32];
    logic [31:0] mem     [MEM_DEPTH];

    // S1 -> S2 pipeline registers
    logic [31:0]       a_q, b_q;
    logic [4:0]        rd1;
    logic [3:0]        func1;
    logic [MEM_AW-1:0] addr1;

    // S2 -> S3 pipeline registers
    logic [31:0]       z_q;
    logic [4:0]        rd2;
    logic [MEM_AW-1:0] addr2;

    logic [31:0] alu_result;
    logic [31:0] op_a, op_b;

    // Only the low MEM_AW address bits select a word; the rest are ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:MEM_AW];

    function automatic logic [31:0] alu(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_MUL:  r = a * b;       // low 32 bits of the product
            ALU_SELA: r = a;
            ALU_SELB: r = b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOTA: r = ~a;
            ALU_NOTB: r = ~b;
            ALU_SRA:  r = a >> 1;      // logical shift despite the name
            ALU_SLA:  r = a << 1;
            default:  r = '0;          // opcodes 12-15
        endcase
        return r;
    endfunction

    assign alu_result = alu(func1, a_q, b_q);

    // Operand selection. The register bank is read combinationally, and its
    // write is a non-blocking update at the same edge, so a read coinciding
    // with an S3 write to the same index sees the old value.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        op_a = regbank[rs1];
        op_b = regbank[rs2];
`ifdef PIPE_FORWARD_EN
        if (rs1 == rd1)      op_a = alu_result;
        else if (rs1 == rd2) op_a = z_q;
        if (rs2 == rd1)      op_b = alu_result;
        else if (rs2 == rd2) op_b = z_q;
`endif
    end

    // Pipeline registers and mem_out. Reset zeroes everything so the ops
    // flushed through after reset are ADD r0+r0 -> r0 storing 0 to mem[0].
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            a_q     <= '0;
            b_q     <= '0;
            rd1     <= '0;
            func1   <= '0;
            addr1   <= '0;
            z_q     <= '0;
            rd2     <= '0;
            addr2   <= '0;
            mem_out <= '0;
        end else begin
            a_q     <= op_a;
            b_q     <= op_b;
            rd1     <= rd;
            func1   <= func;
            addr1   <= addr[MEM_AW-1:0];
            z_q     <= alu_result;
            rd2     <= rd1;
            addr2   <= addr1;
            mem_out <= z_q;
        end
    end

    // Register bank: resets to regbank[i] = i; r0 is an ordinary register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regbank[i] <= 32'(i);
        end else begin
            regbank[rd2] <= z_q;
        end
    end

    // Data memory: a store happens on every non-reset edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: clearing every word on reset rules out RAM-macro
            // inference and builds this array from flops; that is intended
            // because the block must come out of reset with a known memory.
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            mem[addr2] <= z_q;
        end
    end

endmodule

// File: tb/tb_pipeline_processor.sv
// Directed self-checking bench for pipeline_processor (MEM_AW = 8).
// Inputs change and outputs are sampled on the falling edge, half a cycle
// away from the active rising edge. An op driven before rising edge k shows
// on mem_out after edge k+2, i.e. three falling-edge ticks after it is driven.
// Expected values for the hazard cases depend on PIPE_FORWARD_EN.

module tb_pipeline_processor;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  func;
    logic [31:0] addr;
    logic [31:0] mem_out;

    int checks;
    int passes;

    pipeline_processor #(.MEM_AW(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd),
        .func    (func),
        .addr    (addr),
        .mem_out (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU sweep table: rs1, rs2, rd, func, expected result (addr = 0x20 + i).
    localparam int N_SWEEP = 14;
    logic [4:0]  sw_rs1  [N_SWEEP] = '{5'd3, 5'd7, 5'd12, 5'd12, 5'd12, 5'd0, 5'd0,
                                       5'd9, 5'd9, 5'd0, 5'd5, 5'd3, 5'd15, 5'd31};
    logic [4:0]  sw_rs2  [N_SWEEP] = '{5'd4, 5'd8, 5'd10, 5'd10, 5'd10, 5'd0, 5'd9,
                                       5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd2, 5'd31};
    logic [4:0]  sw_rd   [N_SWEEP] = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26,
                                       5'd27, 5'd28, 5'd29, 5'd30, 5'd19, 5'd18, 5'd17};
    logic [3:0]  sw_func [N_SWEEP] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                                       4'd10, 4'd11, 4'd4, 4'd3, 4'd13, 4'd15, 4'd2};
    logic [31:0] sw_exp  [N_SWEEP] = '{32'hFFFF_FFFF, 32'd56, 32'd8, 32'd14, 32'd6,
                                       32'hFFFF_FFFF, 32'hFFFF_FFF6, 32'd4, 32'd18,
                                       32'd7, 32'd5, 32'd0, 32'd0, 32'd961};

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_op(input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d, input logic [3:0] f,
                          input logic [31:0] a);
        rs1  = s1;
        rs2  = s2;
        rd   = d;
        func = f;
        addr = a;
    endtask

    // Filler op that never touches registers or memory words under test:
    // r31 <= r31, stored to mem[0x80].
    task automatic set_idle();
        set_op(5'd31, 5'd31, 5'd31, 4'd3, 32'h80);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_idle();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (mem_out !== 32'd0) $display("FAIL reset_mem_out: got %h want %h", mem_out, 32'd0);
        else passes++;
        checks++;
        if (dut.regbank[10] !== 32'd10) $display("FAIL reset_r10: got %h want %h", dut.regbank[10], 32'd10);
        else passes++;
        checks++;
        if (dut.regbank[31] !== 32'd31) $display("FAIL reset_r31: got %h want %h", dut.regbank[31], 32'd31);
        else passes++;
        checks++;
        if (dut.mem[255] !== 32'd0) $display("FAIL reset_mem255: got %h want %h", dut.mem[255], 32'd0);
        else passes++;
    endtask

    task automatic test_add();
        do_reset();
        set_op(5'd5, 5'd6, 5'd10, 4'd0, 32'h1000);
        tick();
        set_idle();
        tick();
        tick();
        checks++;
        if (mem_out !== 32'd11) $display("FAIL add_mem_out: got %h want %h", mem_out, 32'd11);
        else passes++;
        checks++;
        if (dut.regbank[10] !== 32'd11) $display("FAIL add_r10: got %h want %h", dut.regbank[10], 32'd11);
        else passes++;
        checks++;
        if (dut.mem[0] !== 32'd11) $display("FAIL add_mem0: got %h want %h", dut.mem[0], 32'd11);
        else passes++;
    endtask

    task automatic test_alu_sweep();
        do_reset();
        for (int i = 0; i < N_SWEEP + 2; i++) begin
            if (i < N_SWEEP) set_op(sw_rs1[i], sw_rs2[i], sw_rd[i], sw_func[i], 32'h20 + i);
            else             set_idle();
            tick();
            if (i >= 2) begin
                checks++;
                if (mem_out !== sw_exp[i-2])
                    $display("FAIL sweep_op%0d_func%0d: got %h want %h", i - 2, sw_func[i-2], mem_out, sw_exp[i-2]);
                else passes++;
            end
        end
        checks++;
        if (dut.regbank[21] !== 32'd56) $display("FAIL sweep_r21: got %h want %h", dut.regbank[21], 32'd56);
        else passes++;
        checks++;
        if (dut.mem[8'h20] !== 32'hFFFF_FFFF) $display("FAIL sweep_mem20: got %h want %h", dut.mem[8'h20], 32'hFFFF_FFFF);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] want;
`ifdef PIPE_FORWARD_EN
        want = 32'd12;
`else
        want = 32'd11;
`endif
        do_reset();
        set_op(5'd5, 5'd6, 5'd10, 4'd0, 32'h40);   // r10 = 5 + 6
        tick();
        set_op(5'd10, 5'd1, 5'd12, 4'd0, 32'h41);  // r12 = r10 + r1
        tick();
        set_idle();
        tick();
        checks++;
        if (mem_out !== 32'd11) $display("FAIL b2b_producer: got %h want %h", mem_out, 32'd11);
        else passes++;
        tick();
        checks++;
        if (mem_out !== want) $display("FAIL b2b_consumer: got %h want %h", mem_out, want);
        else passes++;
    endtask

    task automatic test_gap_one();
        logic [31:0] want;
`ifdef PIPE_FORWARD_EN
        want = 32'd12;
`else
        want = 32'd11;   // read coincides with the write edge: old value
`endif
        do_reset();
        set_op(5'd5, 5'd6, 5'd10, 4'd0, 32'h40);
        tick();
        set_idle();
        tick();
        set_op(5'd1, 5'd10, 5'd12, 4'd0, 32'h42);  // r12 = r1 + r10 via rs2
        tick();
        set_idle();
        tick();
        tick();
        checks++;
        if (mem_out !== want) $display("FAIL gap1_consumer: got %h want %h", mem_out, want);
        else passes++;
    endtask

    task automatic test_gap_two();
        do_reset();
        set_op(5'd5, 5'd6, 5'd10, 4'd0, 32'h40);
        tick();
        set_idle();
        tick();
        tick();
        set_op(5'd10, 5'd1, 5'd12, 4'd0, 32'h43);  // reads committed r10 = 11
        tick();
        set_idle();
        tick();
        tick();
        checks++;
        if (mem_out !== 32'd12) $display("FAIL gap2_consumer: got %h want %h", mem_out, 32'd12);
        else passes++;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        set_op(5'd5, 5'd6, 5'd10, 4'd0, 32'h0);
        tick();
        reset = 1'b0;
        set_idle();
        tick();
        reset = 1'b1;
        checks++;
        if (mem_out !== 32'd0) $display("FAIL midrst_mem_out: got %h want %h", mem_out, 32'd0);
        else passes++;
        checks++;
        if (dut.regbank[10] !== 32'd10) $display("FAIL midrst_r10: got %h want %h", dut.regbank[10], 32'd10);
        else passes++;
        tick();
        tick();
        tick();
        checks++;
        if (dut.regbank[10] !== 32'd10) $display("FAIL midrst_r10_late: got %h want %h", dut.regbank[10], 32'd10);
        else passes++;
        checks++;
        if (dut.mem[0] !== 32'd0) $display("FAIL midrst_mem0_late: got %h want %h", dut.mem[0], 32'd0);
        else passes++;
        checks++;
        if (mem_out !== 32'd31) $display("FAIL midrst_idle_out: got %h want %h", mem_out, 32'd31);
        else passes++;
    endtask

    task automatic test_addr_wrap();
        do_reset();
        set_op(5'd5, 5'd0, 5'd13, 4'd3, 32'h1FF);  // store 5 -> mem[0xFF]
        tick();
        set_op(5'd6, 5'd0, 5'd14, 4'd3, 32'h100);  // store 6 -> mem[0x00]
        tick();
        set_idle();
        tick();
        tick();
        checks++;
        if (dut.mem[255] !== 32'd5) $display("FAIL wrap_memFF: got %h want %h", dut.mem[255], 32'd5);
        else passes++;
        checks++;
        if (dut.mem[0] !== 32'd6) $display("FAIL wrap_mem00: got %h want %h", dut.mem[0], 32'd6);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset  = 1'b0;
        set_idle();
        tick();
        test_reset();
        test_add();
        test_alu_sweep();
        test_back_to_back();
        test_gap_one();
        test_gap_two();
        test_reset_mid_op();
        test_addr_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
